// File: rtl/boot_fetch_ctrl.sv
// Boot-and-fetch controller: copies a fixed-length BIOS image from a valid/ready
// stream into memory, then runs a PC that fetches instructions with back-pressure
// and jump redirection.
// Optional read-back verification of the image is compiled in with BOOT_VERIFY_EN.
module boot_fetch_ctrl #(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            BOOT_WORDS     = 16,
  parameter logic [ADDR_WIDTH-1:0]  BOOT_BASE      = '0,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC       = '0,
  parameter int unsigned            BYTES_PER_WORD = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  boot_valid,
  input  logic [DATA_WIDTH-1:0] boot_data,
  output logic                  boot_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  input  logic                  fetch_ready,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] pc_value,
  output logic                  pc_enable,
  output logic                  boot_done,
  output logic                  boot_error,
  output logic                  busy
);

  localparam int unsigned           CntW    = (BOOT_WORDS > 1) ? $clog2(BOOT_WORDS) : 1;
  localparam logic [CntW-1:0]       LastCnt = CntW'(BOOT_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] Stride  = ADDR_WIDTH'(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
`ifdef BOOT_VERIFY_EN
    StVerify,
`endif
    StRun,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q;       // boot word index (write or read-back)
  logic                  wr_pend_q;   // accepted beat waiting for its write cycle
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  rd_q;        // read strobe cycle (first fetch / verify read)
  logic                  cap_q;       // mem_rdata is valid this cycle
  logic                  fv_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  pc_en_q;
  logic                  done_q;

  logic [ADDR_WIDTH-1:0] boot_addr;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  accept;
  logic                  is_last;

  assign boot_addr = BOOT_BASE + ADDR_WIDTH'(cnt_q) * Stride;
  assign pc_next   = jump_valid ? jump_target : pc_q + Stride;
  assign accept    = (state_q == StRun) && fv_q && fetch_ready;
  assign is_last   = (cnt_q == LastCnt);

`ifdef BOOT_VERIFY_EN
  logic [DATA_WIDTH-1:0] csum_q;
  logic [DATA_WIDTH-1:0] vsum_q;
  logic [DATA_WIDTH-1:0] vsum_next;
  logic                  verify_ok;

  assign vsum_next = vsum_q ^ mem_rdata;
  assign verify_ok = (vsum_next == csum_q);
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
`ifdef BOOT_VERIFY_EN
      StLoad: if (wr_pend_q && is_last) state_d = StVerify;
      StVerify: begin
        if (cap_q && is_last) state_d = verify_ok ? StRun : StError;
      end
`else
      StLoad: if (wr_pend_q && is_last) state_d = StRun;
`endif
      default: state_d = state_q;
    endcase
  end

  // Datapath: beat capture, counters, PC and fetch pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_data_q <= '0;
      pc_q      <= RESET_PC;
      rd_q      <= 1'b0;
      cap_q     <= 1'b0;
      fv_q      <= 1'b0;
      instr_q   <= '0;
      pc_en_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef BOOT_VERIFY_EN
      csum_q    <= '0;
      vsum_q    <= '0;
`endif
    end else begin
      pc_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q     <= '0;
            wr_pend_q <= 1'b0;
`ifdef BOOT_VERIFY_EN
            csum_q    <= '0;
`endif
          end
        end
        StLoad: begin
          if (wr_pend_q) begin
            wr_pend_q <= 1'b0;
            if (is_last) begin
              cnt_q <= '0;
              rd_q  <= 1'b1;  // first verify read or first fetch issue
`ifdef BOOT_VERIFY_EN
              vsum_q <= '0;
`else
              done_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end else if (boot_valid) begin
            wr_pend_q <= 1'b1;
            wr_data_q <= boot_data;
`ifdef BOOT_VERIFY_EN
            csum_q    <= csum_q ^ boot_data;
`endif
          end
        end
`ifdef BOOT_VERIFY_EN
        StVerify: begin
          if (rd_q) begin
            rd_q  <= 1'b0;
            cap_q <= 1'b1;
          end else if (cap_q) begin
            cap_q  <= 1'b0;
            vsum_q <= vsum_next;
            if (is_last) begin
              cnt_q <= '0;
              if (verify_ok) begin
                done_q <= 1'b1;
                rd_q   <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
              rd_q  <= 1'b1;
            end
          end
        end
`endif
        StRun: begin
          if (rd_q) begin
            rd_q  <= 1'b0;
            cap_q <= 1'b1;
          end
          if (cap_q) begin
            cap_q   <= 1'b0;
            instr_q <= mem_rdata;
            fv_q    <= 1'b1;
          end
          // Accept issues the next read in the same cycle, so capture follows.
          if (accept) begin
            fv_q    <= 1'b0;
            cap_q   <= 1'b1;
            pc_q    <= pc_next;
            pc_en_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: memory strobes and status
  always_comb begin
    boot_ready  = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    mem_oe      = 1'b0;
    busy        = 1'b0;
    boot_error  = 1'b0;
    unique case (state_q)
      StLoad: begin
        busy       = 1'b1;
        boot_ready = !wr_pend_q;
        if (wr_pend_q) begin
          mem_cs      = 1'b1;
          mem_we      = 1'b1;
          mem_address = boot_addr;
          mem_wdata   = wr_data_q;
        end
      end
`ifdef BOOT_VERIFY_EN
      StVerify: begin
        busy = 1'b1;
        if (rd_q) begin
          mem_cs      = 1'b1;
          mem_oe      = 1'b1;
          mem_address = boot_addr;
        end
      end
      StError: boot_error = 1'b1;
`endif
      StRun: begin
        if (rd_q) begin
          mem_cs      = 1'b1;
          mem_oe      = 1'b1;
          mem_address = pc_q;
        end else if (accept) begin
          mem_cs      = 1'b1;
          mem_oe      = 1'b1;
          mem_address = pc_next;
        end
      end
      default: ;
    endcase
  end

  assign fetch_valid = fv_q;
  assign fetch_instr = instr_q;
  assign pc_value    = pc_q;
  assign pc_enable   = pc_en_q;
  assign boot_done   = done_q;

endmodule

// File: tb/tb_boot_fetch_ctrl.sv
// Directed bench for boot_fetch_ctrl with a memory model and write/fetch scoreboards.
// Also builds with BOOT_VERIFY_EN to exercise the read-back error path.
module tb_boot_fetch_ctrl;

  localparam int unsigned BW = 4;
`ifdef BOOT_VERIFY_EN
  localparam int unsigned BootLat = 4 * BW;
`else
  localparam int unsigned BootLat = 2 * BW;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        boot_valid = 1'b0;
  logic [31:0] boot_data = '0;
  logic        boot_ready;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_cs, mem_we, mem_oe;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_ready = 1'b0;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] pc_value;
  logic        pc_enable, boot_done, boot_error, busy;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned n_acc = 0;
  int unsigned n_pcen = 0;
  int unsigned cyc = 0;
  int unsigned t_mark, t_valid;
  bit          corrupt_104 = 1'b0;

  ent_t        wq[$];
  ent_t        fq[$];
  logic [31:0] mem [logic [31:0]];

  boot_fetch_ctrl #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .BOOT_WORDS    (BW),
    .BOOT_BASE     (32'h100),
    .RESET_PC      (32'h100),
    .BYTES_PER_WORD(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .boot_valid (boot_valid),
    .boot_data  (boot_data),
    .boot_ready (boot_ready),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .mem_rdata  (mem_rdata),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready),
    .jump_valid (jump_valid),
    .jump_target(jump_target),
    .pc_value   (pc_value),
    .pc_enable  (pc_enable),
    .boot_done  (boot_done),
    .boot_error (boot_error),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory: unwritten words read back as the inverted address
  always @(posedge clock) begin
    if (mem_cs && mem_we)
      mem[mem_address] = (corrupt_104 && mem_address == 32'h104) ? 32'hBAD : mem_wdata;
    if (mem_cs && mem_oe)
      mem_rdata <= mem.exists(mem_address) ? mem[mem_address] : ~mem_address;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write scoreboard
  always @(negedge clock) begin
    if (mem_cs === 1'b1 && mem_we === 1'b1) begin
      ent_t e;
      check("write_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check("write_addr", mem_address, e.addr);
        check("write_data", mem_wdata, e.data);
      end
    end
    if (pc_enable === 1'b1) n_pcen++;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_boot_ready"}, 32'(boot_ready), 32'd0);
    check({tag, "_strobes"}, {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    check({tag, "_fetch_valid"}, 32'(fetch_valid), 32'd0);
    check({tag, "_pc_enable"}, 32'(pc_enable), 32'd0);
    check({tag, "_status"}, {29'd0, boot_done, boot_error, busy}, 32'd0);
    check({tag, "_mem_address"}, mem_address, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_fetch_instr"}, fetch_instr, 32'd0);
    check({tag, "_pc_value"}, pc_value, 32'h100);
  endtask

  // Called just after a negedge in IDLE; returns at the negedge of the first LOAD cycle
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Returns at the negedge of the write cycle that follows acceptance
  task automatic send_beat(input logic [31:0] d, input logic [31:0] a);
    int k = 0;
    wq.push_back('{addr: a, data: d});
    boot_valid = 1'b1;
    boot_data  = d;
    while (!boot_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("beat_ready", 32'(boot_ready), 32'd1);
    @(negedge clock);
    boot_valid = 1'b0;
    boot_data  = '0;
  endtask

  task automatic fetch_one(input logic jv, input logic [31:0] jt);
    int k = 0;
    ent_t e;
    logic [31:0] nxt;
    while (!fetch_valid && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("fetch_valid", 32'(fetch_valid), 32'd1);
    t_valid = cyc;
    e = fq.pop_front();
    check("fetch_instr", fetch_instr, e.data);
    check("pc_value", pc_value, e.addr);
    nxt = jv ? jt : e.addr + 32'd4;
    fetch_ready = 1'b1;
    jump_valid  = jv;
    jump_target = jt;
    #1;
    check("issue_oe", {30'd0, mem_cs, mem_oe}, 32'd3);
    check("issue_addr", mem_address, nxt);
    @(negedge clock);
    n_acc++;
    fetch_ready = 1'b0;
    jump_valid  = 1'b0;
    check("pc_enable", 32'(pc_enable), 32'd1);
    check("pc_update", pc_value, nxt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int unsigned t_prev;

    // Reset state
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Boot 1: gap after the second beat
`ifdef BOOT_VERIFY_EN
    corrupt_104 = 1'b1;
`endif
    pulse_start();
    check("busy_load", 32'(busy), 32'd1);
    send_beat(32'hA, 32'h100);
    send_beat(32'hB, 32'h104);
    repeat (3) @(negedge clock);
    send_beat(32'hC, 32'h108);
    send_beat(32'hD, 32'h10C);
`ifdef BOOT_VERIFY_EN
    k = 0;
    while (!boot_error && k < 60) begin
      @(negedge clock);
      k++;
    end
    check("boot_error", 32'(boot_error), 32'd1);
    check("boot_done_on_error", 32'(boot_done), 32'd0);
    check("busy_error", 32'(busy), 32'd0);
    k = 0;
    repeat (10) begin
      @(negedge clock);
      if (fetch_valid !== 1'b0) k++;
    end
    check("no_fetch_after_error", 32'(k), 32'd0);
    corrupt_104 = 1'b0;
`else
    k = 0;
    while (!boot_done && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("boot_done", 32'(boot_done), 32'd1);
    check("busy_run", 32'(busy), 32'd0);
    check("boot_error", 32'(boot_error), 32'd0);
`endif

    // Reset from RUN/ERROR, then reset again mid-load after two beats
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("pc_after_reset", pc_value, 32'h100);
    pulse_start();
    send_beat(32'h1, 32'h100);
    send_beat(32'h2, 32'h104);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midload_reset");
    reset = 1'b0;

    // Boot 2: back-to-back beats, latency measured from the first LOAD cycle
    pulse_start();
    t_mark = cyc;
    send_beat(32'hA, 32'h100);
    send_beat(32'hB, 32'h104);
    send_beat(32'hC, 32'h108);
    send_beat(32'hD, 32'h10C);
    k = 0;
    while (!boot_done && k < 60) begin
      @(negedge clock);
      k++;
    end
    check("boot2_done", 32'(boot_done), 32'd1);
    check("boot_latency", cyc - t_mark, BootLat);
    t_mark = cyc;
    k = 0;
    while (!fetch_valid && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("first_fetch_latency", cyc - t_mark, 32'd2);

    // Sequential fetches
    fq.push_back('{addr: 32'h100, data: 32'hA});
    fq.push_back('{addr: 32'h104, data: 32'hB});
    fq.push_back('{addr: 32'h108, data: 32'hC});
    fq.push_back('{addr: 32'h10C, data: 32'hD});
    fetch_one(1'b0, '0);
    t_prev = t_valid;
    fetch_one(1'b0, '0);
    check("fetch_throughput", t_valid - t_prev, 32'd2);
    fetch_one(1'b0, '0);

    // Back-pressure: hold for 5 cycles with a stray jump request
    k = 0;
    while (!fetch_valid && k < 10) begin
      @(negedge clock);
      k++;
    end
    jump_valid  = 1'b1;
    jump_target = 32'h300;
    repeat (5) begin
      @(negedge clock);
      check("hold_valid", 32'(fetch_valid), 32'd1);
      check("hold_instr", fetch_instr, 32'hD);
      check("hold_pc", pc_value, 32'h10C);
      check("hold_no_strobe", {30'd0, mem_cs, mem_oe}, 32'd0);
    end
    jump_valid = 1'b0;

    // Jumps, including PC wrap-around
    fq.push_back('{addr: 32'h200, data: ~32'h200});
    fetch_one(1'b1, 32'h200);
    fq.push_back('{addr: 32'hFFFF_FFFC, data: ~32'hFFFF_FFFC});
    fetch_one(1'b1, 32'hFFFF_FFFC);
    fq.push_back('{addr: 32'h0, data: ~32'h0});
    fetch_one(1'b0, '0);
    fetch_one(1'b0, '0);

    repeat (3) @(negedge clock);
    check("pc_enable_pulses", n_pcen, n_acc);
    check("write_queue_empty", wq.size(), 32'd0);
    check("fetch_queue_empty", fq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
